l2_port_arbiter: RTL and testbench
==================================

L2_PORT_ARBITER -- requirements
Module: l2_port_arbiter

Interface
REQ-001 Parameter: ADDR_W, 26, line-address width (address bits [31:6]).
REQ-002 Parameter: TIMEOUT, 255, maximum cycles in BUSY without l2_ack; range 1..65535.
REQ-003 clk  input  1  single system clock; all state changes on posedge clk.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 i_cmd  input  2  instruction-cache command to L2; NOP=00, READ=01, WRITE=10, RW=11.
REQ-006 i_add  input  ADDR_W  instruction-cache line address.
REQ-007 i_ready  output  1  one-cycle pulse: instruction request accepted.
REQ-008 d_cmd  input  2  data-cache command, same encoding as i_cmd.
REQ-009 d_add  input  ADDR_W  data-cache line address.
REQ-010 d_ready  output  1  one-cycle pulse: data request accepted.
REQ-011 l2_cmd  output  2  command to the next-level cache.
REQ-012 l2_add  output  ADDR_W  address to the next-level cache.
REQ-013 l2_ack  input  1  next-level cache completion, sampled only in BUSY.
REQ-014 busy  output  1  high while a transaction is outstanding.
REQ-015 err  output  1  sticky timeout flag.

Function
REQ-016 The FSM SHALL have two states: IDLE (waiting for a request) and BUSY (one transaction outstanding).
- A requester is pending when its cmd != NOP.
- It holds cmd and add stable until its ready pulse.
REQ-017 In IDLE with exactly one requester pending, that requester SHALL win at the next posedge.
REQ-018 In IDLE with both pending, the grant SHALL go to the requester named by the round-robin pointer.
- The pointer resets to DATA.
- After every grant it points to the requester that lost.
REQ-019 At the grant edge the block SHALL:
- latch the winner's cmd/add into output registers;
- enter BUSY;
- assert the winner's ready for exactly the following cycle.
REQ-020 In BUSY, l2_cmd/l2_add SHALL hold the latched values; i_cmd and d_cmd are ignored.
REQ-021 When l2_ack is sampled high in BUSY, the block SHALL:
- enter IDLE;
- drive l2_cmd=NOP and l2_add=0 from the next cycle.
REQ-022 IDLE SHALL last at least one cycle; the minimum grant-to-grant spacing is 2 cycles plus the ack latency.
REQ-023 l2_ack sampled in IDLE SHALL be ignored, with no state or output change.
REQ-024 The timeout counter SHALL:
- clear on entry to BUSY;
- increment each BUSY cycle without l2_ack.
REQ-025 When the timeout count reaches TIMEOUT, the block SHALL:
- set err;
- return to IDLE, driving NOP;
- leave the pointer as updated at the grant.
REQ-026 l2_ack and timeout on the same edge SHALL be treated as a normal ack; err stays unchanged.
REQ-027 Outside IDLE, i_ready and d_ready SHALL never be high together and never high for two consecutive cycles.

Reset
REQ-028 While rst is high, the block SHALL hold the following, regardless of clk:
- state IDLE, pointer DATA;
- l2_cmd=NOP, l2_add=0;
- i_ready=0, d_ready=0, busy=0, err=0;
- timeout counter 0.
REQ-029 rst asserted mid-BUSY SHALL abandon the transaction without a ready or retry; the first grant is possible at the first posedge after rst deasserts.

Configuration
REQ-030 Macro ARB_STATS_EN, when defined, SHALL add the 32-bit outputs i_grants, d_grants and timeouts.
- Each increments once per event and wraps at 2^32.
- All three clear on rst.
REQ-031 Without ARB_STATS_EN, those ports and counters SHALL be absent; all other behaviour is identical.

Structure
REQ-032 The command encodings (NOP/READ/WRITE/RW), the requester ID enum (INST/DATA) and the FSM state enum SHALL reside in a shared package, cache_pkg, also used by the data and instruction caches.
REQ-033 Round-robin pick logic SHALL be one sub-module, rr_pick2 (inputs: two pending bits and the pointer; outputs: grant and valid).

Verification
REQ-034 Single request: d_cmd=READ, d_add=0x0ABCDEF, ack 3 cycles later -> d_ready pulses 1 cycle after request; l2_cmd=01, l2_add=0x0ABCDEF for 3 cycles; then NOP.
REQ-035 Contention: both pending after reset (i READ 0x100, d WRITE 0x200), 1-cycle ack, requesters hold -> grant order D, I, D, I; the l2_add sequence is 0x200, 0x100, 0x200, 0x100.
REQ-036 Timeout: TIMEOUT=4, d READ, no ack -> after 4 BUSY cycles, err=1 and l2_cmd=NOP; the next i request is still served normally.
REQ-037 Reset mid-op: rst pulsed during BUSY -> l2_cmd=NOP, busy=0, err=0 immediately; the pointer is DATA afterwards.
REQ-038 Spurious ack: l2_ack=1 in IDLE with no requests -> no output change, busy stays 0.
REQ-039 Stats (ARB_STATS_EN): 5 D grants, 3 I grants, 1 timeout -> d_grants=5, i_grants=3, timeouts=1; all are 0 after rst.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared definitions for the L1 caches and the L2 port arbiter:
// command encodings, requester IDs and the arbiter FSM state.
package cache_pkg;

    typedef enum logic [1:0] {
        CMD_NOP   = 2'b00,
        CMD_READ  = 2'b01,
        CMD_WRITE = 2'b10,
        CMD_RW    = 2'b11
    } cmd_e;

    typedef enum logic {
        REQ_INST = 1'b0,
        REQ_DATA = 1'b1
    } req_id_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

    localparam int STAT_W = 32;
    localparam int TCNT_W = 16;

    // The requester that did not win; the round-robin pointer moves here.
    function automatic req_id_e other_req(input req_id_e id);
        return (id == REQ_INST) ? REQ_DATA : REQ_INST;
    endfunction

    function automatic logic is_pending(input logic [1:0] cmd);
        return cmd != CMD_NOP;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: a lone requester always wins, a tie goes to
// the requester named by the pointer.
module rr_pick2
    import cache_pkg::*;
(
    input  logic    pend_i,
    input  logic    pend_d,
    input  req_id_e ptr,
    output req_id_e grant,
    output logic    valid
);

    // Pure combinational selection.
    always_comb begin
        valid = pend_i | pend_d;
        grant = ptr;
        if (pend_i && !pend_d) begin
            grant = REQ_INST;
        end else if (pend_d && !pend_i) begin
            grant = REQ_DATA;
        end
    end

endmodule

// File: rtl/l2_port_arbiter.sv
// Arbitrates the instruction and data caches onto a single L2 port.
// One transaction outstanding at a time, round-robin on contention,
// timeout with a sticky err flag.
// Optional feature: define ARB_STATS_EN to add the i_grants, d_grants and
// timeouts event counters.
module l2_port_arbiter
    import cache_pkg::*;
#(
    parameter int ADDR_W  = 26,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        i_cmd,
    input  logic [ADDR_W-1:0] i_add,
    output logic              i_ready,
    input  logic [1:0]        d_cmd,
    input  logic [ADDR_W-1:0] d_add,
    output logic              d_ready,
    output logic [1:0]        l2_cmd,
    output logic [ADDR_W-1:0] l2_add,
    input  logic              l2_ack,
    output logic              busy,
    output logic              err
`ifdef ARB_STATS_EN
    ,
    output logic [STAT_W-1:0] i_grants,
    output logic [STAT_W-1:0] d_grants,
    output logic [STAT_W-1:0] timeouts
`endif
);

    // Count value seen on the edge that completes the TIMEOUT-th idle BUSY cycle.
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);

    arb_state_e          state_q, state_d;
    req_id_e             ptr_q, ptr_d;
    logic [1:0]          l2_cmd_q, l2_cmd_d;
    logic [ADDR_W-1:0]   l2_add_q, l2_add_d;
    logic                i_ready_q, i_ready_d;
    logic                d_ready_q, d_ready_d;
    logic                err_q, err_d;
    logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
    logic                grant_i_evt, grant_d_evt, timeout_evt;

    req_id_e             pick_grant;
    logic                pick_valid;

    rr_pick2 u_pick (
        .pend_i (is_pending(i_cmd)),
        .pend_d (is_pending(d_cmd)),
        .ptr    (ptr_q),
        .grant  (pick_grant),
        .valid  (pick_valid)
    );

    // Next-state and registered-output computation for the IDLE/BUSY FSM.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        l2_cmd_d    = l2_cmd_q;
        l2_add_d    = l2_add_q;
        i_ready_d   = 1'b0;
        d_ready_d   = 1'b0;
        err_d       = err_q;
        tcnt_d      = tcnt_q;
        grant_i_evt = 1'b0;
        grant_d_evt = 1'b0;
        timeout_evt = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // l2_ack is deliberately not looked at here.
                if (pick_valid) begin
                    state_d = ST_BUSY;
                    ptr_d   = other_req(pick_grant);
                    tcnt_d  = '0;
                    if (pick_grant == REQ_INST) begin
                        l2_cmd_d    = i_cmd;
                        l2_add_d    = i_add;
                        i_ready_d   = 1'b1;
                        grant_i_evt = 1'b1;
                    end else begin
                        l2_cmd_d    = d_cmd;
                        l2_add_d    = d_add;
                        d_ready_d   = 1'b1;
                        grant_d_evt = 1'b1;
                    end
                end
            end
            ST_BUSY: begin
                // An ack wins over a simultaneous timeout and leaves err alone.
                if (l2_ack) begin
                    state_d  = ST_IDLE;
                    l2_cmd_d = CMD_NOP;
                    l2_add_d = '0;
                end else if (tcnt_q >= TCNT_LAST) begin
                    state_d     = ST_IDLE;
                    l2_cmd_d    = CMD_NOP;
                    l2_add_d    = '0;
                    err_d       = 1'b1;
                    timeout_evt = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + TCNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state and registered outputs; reset abandons any transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ptr_q     <= REQ_DATA;
            l2_cmd_q  <= CMD_NOP;
            l2_add_q  <= '0;
            i_ready_q <= 1'b0;
            d_ready_q <= 1'b0;
            err_q     <= 1'b0;
            tcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            l2_cmd_q  <= l2_cmd_d;
            l2_add_q  <= l2_add_d;
            i_ready_q <= i_ready_d;
            d_ready_q <= d_ready_d;
            err_q     <= err_d;
            tcnt_q    <= tcnt_d;
        end
    end

    assign i_ready = i_ready_q;
    assign d_ready = d_ready_q;
    assign l2_cmd  = l2_cmd_q;
    assign l2_add  = l2_add_q;
    assign busy    = (state_q == ST_BUSY);
    assign err     = err_q;

`ifdef ARB_STATS_EN
    logic [STAT_W-1:0] i_grants_q, d_grants_q, timeouts_q;

    // Free-running event counters, wrapping naturally at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_grants_q <= '0;
            d_grants_q <= '0;
            timeouts_q <= '0;
        end else begin
            if (grant_i_evt) i_grants_q <= i_grants_q + STAT_W'(1);
            if (grant_d_evt) d_grants_q <= d_grants_q + STAT_W'(1);
            if (timeout_evt) timeouts_q <= timeouts_q + STAT_W'(1);
        end
    end

    assign i_grants = i_grants_q;
    assign d_grants = d_grants_q;
    assign timeouts = timeouts_q;
`else
    logic unused_evt;
    assign unused_evt = grant_i_evt ^ grant_d_evt ^ timeout_evt;
`endif

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Self-checking bench for l2_port_arbiter: directed scenarios followed by
// random request/latency traffic against a transaction-level model.
module tb_l2_port_arbiter;
    import cache_pkg::*;

    localparam int AW = 26;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    i_cmd, d_cmd, l2_cmd;
    logic [AW-1:0] i_add, d_add, l2_add;
    logic          i_ready, d_ready, l2_ack, busy, err;
`ifdef ARB_STATS_EN
    logic [31:0]   i_grants, d_grants, timeouts;
`endif

    always #5 clk = ~clk;

    l2_port_arbiter #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_cmd   (i_cmd),
        .i_add   (i_add),
        .i_ready (i_ready),
        .d_cmd   (d_cmd),
        .d_add   (d_add),
        .d_ready (d_ready),
        .l2_cmd  (l2_cmd),
        .l2_add  (l2_add),
        .l2_ack  (l2_ack),
        .busy    (busy),
        .err     (err)
`ifdef ARB_STATS_EN
        ,
        .i_grants(i_grants),
        .d_grants(d_grants),
        .timeouts(timeouts)
`endif
    );

    int checks   = 0;
    int failures = 0;
    int txn_n    = 0;

    // Model state: who wins a tie (1 = data, 0 = inst), sticky error, event counts.
    int   prio_m;
    logic err_m;
    int   ig_m, dg_m, to_m;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".busy"},    32'(busy),    32'd0);
        check({tag, ".l2_cmd"},  32'(l2_cmd),  32'd0);
        check({tag, ".l2_add"},  32'(l2_add),  32'd0);
        check({tag, ".i_ready"}, 32'(i_ready), 32'd0);
        check({tag, ".d_ready"}, 32'(d_ready), 32'd0);
        check({tag, ".err"},     32'(err),     32'(err_m));
    endtask

    task automatic check_stats(input string tag);
`ifdef ARB_STATS_EN
        check({tag, ".i_grants"}, i_grants, 32'(ig_m));
        check({tag, ".d_grants"}, d_grants, 32'(dg_m));
        check({tag, ".timeouts"}, timeouts, 32'(to_m));
`endif
    endtask

    task automatic model_reset();
        prio_m = 1;
        err_m  = 1'b0;
        ig_m   = 0;
        dg_m   = 0;
        to_m   = 0;
    endtask

    // Apply a reset while idle and confirm every output is cleared at once.
    task automatic do_reset(input string tag);
        rst    = 1'b1;
        i_cmd  = 2'b00;
        d_cmd  = 2'b00;
        l2_ack = 1'b0;
        model_reset();
        #1;
        check_idle(tag);
        check_stats(tag);
        tick();
        rst = 1'b0;
    endtask

    // One transaction: grant decided from the currently driven requests,
    // then `lat` cycles until ack (ack never comes if lat exceeds TO).
    task automatic run_txn(input int lat, input string tag);
        int            w;
        int            n;
        logic [1:0]    wc;
        logic [AW-1:0] wa;
        logic          ip, dp;
        ip = (i_cmd != 2'b00);
        dp = (d_cmd != 2'b00);
        if (!ip && !dp) begin
            tick();
            check_idle({tag, ".idle"});
            return;
        end
        w  = (ip && dp) ? prio_m : (dp ? 1 : 0);
        wc = (w == 1) ? d_cmd : i_cmd;
        wa = (w == 1) ? d_add : i_add;
        prio_m = 1 - w;
        if (w == 1) dg_m++; else ig_m++;
        l2_ack = 1'b0;
        tick();
        txn_n++;
        $display("txn %0d %s winner=%s cmd=%0d add=0x%07h lat=%0d", txn_n, tag,
                 (w == 1) ? "D" : "I", wc, wa, lat);
        check({tag, ".busy"},    32'(busy),    32'd1);
        check({tag, ".i_ready"}, 32'(i_ready), 32'(w == 0));
        check({tag, ".d_ready"}, 32'(d_ready), 32'(w == 1));
        check({tag, ".l2_cmd"},  32'(l2_cmd),  32'(wc));
        check({tag, ".l2_add"},  32'(l2_add),  32'(wa));
        if (w == 1) d_cmd = 2'b00; else i_cmd = 2'b00;
        n = (lat < TO) ? lat : TO;
        for (int k = 1; k <= n; k++) begin
            l2_ack = (k == lat);
            tick();
            if (k < n) begin
                check({tag, ".hold_busy"}, 32'(busy),              32'd1);
                check({tag, ".hold_cmd"},  32'(l2_cmd),            32'(wc));
                check({tag, ".hold_add"},  32'(l2_add),            32'(wa));
                check({tag, ".hold_rdy"},  32'({i_ready, d_ready}), 32'd0);
            end
        end
        l2_ack = 1'b0;
        if (lat > TO) begin
            err_m = 1'b1;
            to_m++;
        end
        check_idle({tag, ".done"});
    endtask

    initial begin
        rst    = 1'b1;
        i_cmd  = 2'b00;
        d_cmd  = 2'b00;
        i_add  = '0;
        d_add  = '0;
        l2_ack = 1'b0;
        model_reset();
        tick();
        do_reset("reset");

        // Spurious ack while idle must change nothing.
        l2_ack = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_idle("spurious_ack");
        end
        l2_ack = 1'b0;

        // Single data read, ack three cycles after the grant.
        d_cmd = 2'b01;
        d_add = 26'h0ABCDEF;
        run_txn(3, "single");

        // Contention straight after reset: D, I, D, I.
        do_reset("reset2");
        for (int k = 0; k < 4; k++) begin
            i_cmd = 2'b01; i_add = 26'h100;
            d_cmd = 2'b10; d_add = 26'h200;
            run_txn(1, "contend");
            check("contend.order", 32'(prio_m), 32'((k % 2 == 0) ? 0 : 1));
        end
        i_cmd = 2'b00;
        d_cmd = 2'b00;

        // Timeout, then a normal instruction request.
        d_cmd = 2'b01; d_add = 26'h3;
        run_txn(TO + 2, "timeout");
        check("timeout.err", 32'(err), 32'd1);
        i_cmd = 2'b01; i_add = 26'h55;
        run_txn(2, "after_to");
        // Ack on the same edge as the timeout is a normal completion.
        i_cmd = 2'b10; i_add = 26'h66;
        run_txn(TO, "ack_at_to");

        // Reset in the middle of a data transaction.
        d_cmd = 2'b01; d_add = 26'h77;
        tick();
        check("midrst.d_ready", 32'(d_ready), 32'd1);
        d_cmd = 2'b00;
        tick();
        check("midrst.busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        model_reset();
        #1;
        check_idle("midrst");
        check_stats("midrst");
        tick();
        rst = 1'b0;
        i_cmd = 2'b11; i_add = 26'h1234;
        d_cmd = 2'b10; d_add = 26'h5678;
        run_txn(2, "post_rst");

        // Random traffic; requesters hold until served.
        for (int t = 0; t < 40; t++) begin
            if (i_cmd == 2'b00 && ($urandom % 2) == 1) begin
                i_cmd = 2'($urandom_range(1, 3));
                i_add = AW'($urandom);
            end
            if (d_cmd == 2'b00 && ($urandom % 2) == 1) begin
                d_cmd = 2'($urandom_range(1, 3));
                d_add = AW'($urandom);
            end
            if (i_cmd == 2'b00 && d_cmd == 2'b00) l2_ack = 1'($urandom);
            run_txn(int'($urandom_range(1, TO + 2)), "rand");
        end
        check_stats("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
